// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program-memory loader and the accumulator core.
package prog_loader_pkg;

  localparam int INSTR_W   = 11;
  localparam int PM_ADDR_W = 8;

  localparam logic [7:0] HEADER_BYTE_DEF = 8'hA5;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_LDI = 3'd2;
  localparam logic [2:0] OP_ST  = 3'd3;
  localparam logic [2:0] OP_BL  = 3'd4;

  typedef enum logic [2:0] {
    S_HUNT,
    S_COUNT,
    S_HI,
    S_LO,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input, program-memory write port and run/status lines of the loader.
interface prog_loader_if;
  import prog_loader_pkg::*;

  logic                 rx_valid;
  logic [7:0]           rx_data;
  logic                 rx_ready;
  logic                 pm_we;
  logic [PM_ADDR_W-1:0] pm_addr;
  logic [INSTR_W-1:0]   pm_wdata;
  logic                 cpu_run;
  logic                 load_error;

  // master = stream source / system side, slave = the loader
  modport master (
    output rx_valid, rx_data,
    input  rx_ready, pm_we, pm_addr, pm_wdata, cpu_run, load_error
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, pm_we, pm_addr, pm_wdata, cpu_run, load_error
  );

endinterface

// File: rtl/prog_loader.sv
// Frame parser that writes program memory and releases the core only after a clean checksum.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [7:0] HEADER_BYTE = HEADER_BYTE_DEF
) (
  input  logic         clk,
  input  logic         reset_n,
  prog_loader_if.slave bus
);

  state_t                r_state, w_state_nxt;
  logic [7:0]            r_cnt, r_idx, r_sum;
  logic [2:0]            r_hi;
  logic                  r_live;
  logic                  r_pm_we;
  logic [PM_ADDR_W-1:0]  r_pm_addr;
  logic [INSTR_W-1:0]    r_pm_wdata;

  logic                  w_acc, w_hdr, w_last;
  logic [7:0]            w_sum_add;

  assign w_acc     = bus.rx_valid && bus.rx_ready;
  assign w_hdr     = (bus.rx_data == HEADER_BYTE);
  assign w_sum_add = r_sum + bus.rx_data;
  // count 0 means 256: the 256th pair has idx 255, and 255+1 wraps to 0
  assign w_last    = ((r_idx + 8'd1) == r_cnt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_HUNT;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_acc) begin
      case (r_state)
        S_HUNT, S_ERROR: if (w_hdr) w_state_nxt = S_COUNT;
        S_COUNT:         w_state_nxt = S_HI;
        S_HI:            w_state_nxt = (bus.rx_data[7:3] != 5'd0) ? S_ERROR : S_LO;
        S_LO:            w_state_nxt = w_last ? S_CSUM : S_HI;
        S_CSUM:          w_state_nxt = (w_sum_add == 8'd0) ? S_DONE : S_ERROR;
        default:         w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_live     <= 1'b0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_sum      <= '0;
      r_hi       <= '0;
      r_pm_we    <= 1'b0;
      r_pm_addr  <= '0;
      r_pm_wdata <= '0;
    end else begin
      r_live  <= 1'b1;
      r_pm_we <= 1'b0;
      if (w_acc) begin
        case (r_state)
          S_HUNT, S_ERROR: if (w_hdr) begin
            r_idx <= '0;
            r_sum <= '0;
          end
          S_COUNT: begin
            r_cnt <= bus.rx_data;
            r_sum <= w_sum_add;
          end
          S_HI: begin
            r_hi  <= bus.rx_data[2:0];
            r_sum <= w_sum_add;
          end
          S_LO: begin
            r_sum      <= w_sum_add;
            r_pm_we    <= 1'b1;
            r_pm_addr  <= r_idx;
            r_pm_wdata <= {r_hi, bus.rx_data};
            r_idx      <= r_idx + 8'd1;
          end
          S_CSUM:  r_sum <= w_sum_add;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus.rx_ready   = r_live && (r_state != S_DONE);
    bus.cpu_run    = (r_state == S_DONE);
    bus.load_error = (r_state == S_ERROR);
    bus.pm_we      = r_pm_we;
    bus.pm_addr    = r_pm_addr;
    bus.pm_wdata   = r_pm_wdata;
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: expected writes queued as bytes are sent, popped on pm_we.
module tb_prog_loader;
  import prog_loader_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  prog_loader_if bus();

  prog_loader #(.HEADER_BYTE(8'hA5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [7:0]  a;
    logic [10:0] d;
  } wr_t;

  wr_t        exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] fr_hi[256];
  logic [7:0] fr_lo[256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // every pm_we pulse must match the oldest queued write
  always @(negedge clk) begin
    if (reset_n && bus.pm_we) begin
      logic [31:0] expw;
      if (exp_q.size() > 0) begin
        wr_t e;
        e = exp_q.pop_front();
        expw = {13'b0, e.a, e.d};
      end else begin
        expw = 32'hDEAD_0000;
      end
      chk("pm_write", {13'b0, bus.pm_addr, bus.pm_wdata}, expw);
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    int t;
    bus.rx_valid = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    t = 0;
    forever begin
      @(posedge clk);
      if (bus.rx_ready) break;
      t++;
      if (t >= 20) begin
        chk("rx_ready_timeout", 32'(bus.rx_ready), 32'd1);
        break;
      end
    end
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [7:0] csum_adj, input int maxgap);
    logic [7:0] s;
    s = 8'(n);
    send(8'hA5, $urandom_range(maxgap, 0));
    send(8'(n), $urandom_range(maxgap, 0));
    for (int i = 0; i < n; i++) begin
      send(fr_hi[i], $urandom_range(maxgap, 0));
      s = s + fr_hi[i];
      exp_q.push_back('{a: 8'(i), d: {fr_hi[i][2:0], fr_lo[i]}});
      send(fr_lo[i], $urandom_range(maxgap, 0));
      s = s + fr_lo[i];
    end
    send((8'd0 - s) + csum_adj, $urandom_range(maxgap, 0));
  endtask

  task automatic do_reset();
    @(negedge clk) reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic set_basic();
    fr_hi[0] = 8'h02; fr_lo[0] = 8'h05;
    fr_hi[1] = 8'h03; fr_lo[1] = 8'h00;
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rx_ready",   32'(bus.rx_ready),   32'd0);
    chk("rst_pm_we",      32'(bus.pm_we),      32'd0);
    chk("rst_pm_addr",    32'(bus.pm_addr),    32'd0);
    chk("rst_pm_wdata",   32'(bus.pm_wdata),   32'd0);
    chk("rst_cpu_run",    32'(bus.cpu_run),    32'd0);
    chk("rst_load_error", 32'(bus.load_error), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 32'(bus.rx_ready), 32'd1);

    // basic two-pair frame, checksum F4
    set_basic();
    send_frame(2, 8'h00, 0);
    chk("basic_cpu_run",  32'(bus.cpu_run),    32'd1);
    chk("basic_rx_ready", 32'(bus.rx_ready),   32'd0);
    chk("basic_err",      32'(bus.load_error), 32'd0);
    chk("basic_pending",  32'(exp_q.size()),   32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("done_hold", {30'd0, bus.cpu_run, bus.rx_ready}, 32'd2);
    do_reset();

    // bad checksum F5, then a good frame recovers
    send_frame(2, 8'h01, 0);
    chk("badcs_err",     32'(bus.load_error), 32'd1);
    chk("badcs_run",     32'(bus.cpu_run),    32'd0);
    chk("badcs_pending", 32'(exp_q.size()),   32'd0);
    send_frame(2, 8'h00, 0);
    chk("recover_run", 32'(bus.cpu_run),    32'd1);
    chk("recover_err", 32'(bus.load_error), 32'd0);
    do_reset();

    // illegal hi byte, junk ignored until header
    send(8'hA5, 0); send(8'h01, 0); send(8'h08, 0);
    chk("badhi_err", 32'(bus.load_error), 32'd1);
    send(8'h00, 0); send(8'hFF, 0);
    chk("junk_err",   32'(bus.load_error), 32'd1);
    chk("junk_ready", 32'(bus.rx_ready),   32'd1);
    send(8'hA5, 0);
    chk("hdr_clears_err", 32'(bus.load_error), 32'd0);
    send(8'h01, 0); send(8'h01, 0);
    exp_q.push_back('{a: 8'h00, d: 11'h123});
    send(8'h23, 0); send(8'hDB, 0);
    chk("after_err_run", 32'(bus.cpu_run), 32'd1);
    do_reset();

    // full 256-entry image, index wraps
    for (int i = 0; i < 256; i++) begin
      fr_hi[i] = 8'($urandom_range(7, 0));
      fr_lo[i] = 8'($urandom_range(255, 0));
    end
    send_frame(256, 8'h00, 0);
    chk("full_run",     32'(bus.cpu_run),  32'd1);
    chk("full_pending", 32'(exp_q.size()), 32'd0);
    do_reset();

    // garbage then gapped stream
    set_basic();
    send(8'h11, $urandom_range(3, 0));
    send(8'h22, $urandom_range(3, 0));
    send(8'hA4, $urandom_range(3, 0));
    chk("garbage_err", 32'(bus.load_error), 32'd0);
    send_frame(2, 8'h00, 3);
    chk("gap_run",     32'(bus.cpu_run),  32'd1);
    chk("gap_pending", 32'(exp_q.size()), 32'd0);
    do_reset();

    // reset in the middle of a load
    send(8'hA5, 0); send(8'h02, 0); send(8'h02, 0);
    exp_q.push_back('{a: 8'h00, d: 11'h205});
    send(8'h05, 0);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready",  32'(bus.rx_ready),   32'd0);
    chk("mid_rst_we",     32'(bus.pm_we),      32'd0);
    chk("mid_rst_wdata",  32'(bus.pm_wdata),   32'd0);
    chk("mid_rst_run",    32'(bus.cpu_run),    32'd0);
    chk("mid_rst_err",    32'(bus.load_error), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(2, 8'h00, 0);
    chk("post_rst_run", 32'(bus.cpu_run),  32'd1);
    chk("final_pending", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    chk("global_timeout", 32'(bus.cpu_run), 32'hFFFF_FFFF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
